// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the SRAM-like instruction bus with
// at most one request outstanding, and presents {pc, inst, exception_type} to if_id.
// Handles stall hold, taken-branch redirect, exception flush/redirect and AdEL
// detection on misaligned fetch addresses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADEL_BIT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  stall,
  input  logic        exception,
  input  logic [31:0] exception_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] exception_type_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // issue a request for pc
    S_WAIT = 2'd1,  // request accepted, awaiting read data
    S_OUT  = 2'd2,  // instruction presented to if_id
    S_DROP = 2'd3   // flushed while a request is in flight; swallow its data
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;
  logic [31:0] exc_q,   exc_d;

  logic        misaligned;
  logic [31:0] adel_flag;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign adel_flag  = 32'd1 << ADEL_BIT;

  // Bus request side: a misaligned PC never reaches the bus, and nothing is
  // requested while reset is asserted.
  assign inst_req  = rst && (state_q == S_REQ) && !misaligned;
  assign inst_addr = pc_q;

  // Presentation side: everything reads zero unless an instruction is held.
  assign valid_o          = rst && (state_q == S_OUT);
  assign pc_o             = valid_o ? pc_q   : 32'd0;
  assign inst_o           = valid_o ? inst_q : 32'd0;
  assign exception_type_o = valid_o ? exc_q  : 32'd0;

  // Next-state / next-PC logic; exception flush takes priority over everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    exc_d   = exc_q;

    if (exception) begin
      pc_d = exception_pc;
      case (state_q)
        // An accepted request still owes us a data beat, so drain it.
        S_REQ:   state_d = (inst_req && inst_addr_ok) ? S_DROP : S_REQ;
        S_WAIT:  state_d = inst_data_ok ? S_REQ : S_DROP;
        S_OUT:   state_d = S_REQ;
        S_DROP:  state_d = inst_data_ok ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (misaligned) begin
            // Address error: present a null instruction flagged AdEL.
            inst_d  = 32'd0;
            exc_d   = adel_flag;
            state_d = S_OUT;
          end else if (inst_addr_ok) begin
            exc_d   = 32'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            inst_d  = inst_rdata;
            exc_d   = 32'd0;
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          // if_id samples us only when the whole pipe is unstalled.
          if (stall == 4'b0000) begin
            pc_d    = branch_flag ? branch_target : (pc_q + 32'd4);
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      exc_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a hand-driven instruction bus, expected
// presentations queued when data is returned and compared when valid_o shows.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  stall;
  logic        exception;
  logic [31:0] exception_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic [31:0] exception_type_o;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .exception        (exception),
    .exception_pc     (exception_pc),
    .branch_flag      (branch_flag),
    .branch_target    (branch_target),
    .inst_req         (inst_req),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata),
    .valid_o          (valid_o),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .exception_type_o (exception_type_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] exc;
  } exp_t;

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Wait (bounded) for a request, check its address, accept it.
  task automatic do_req(input string tag, input logic [31:0] exp_addr);
    int i;
    for (i = 0; i < 10; i++) begin
      if (inst_req === 1'b1) break;
      cyc();
    end
    chk({tag, "_req_seen"}, {31'd0, inst_req}, 32'd1);
    chk({tag, "_addr"}, inst_addr, exp_addr);
    inst_addr_ok = 1'b1;
    cyc();
    inst_addr_ok = 1'b0;
  endtask

  // Return data for an outstanding request and queue the expected presentation.
  task automatic do_data(input string tag, input logic [31:0] pc, input logic [31:0] rdata);
    exp_t e;
    chk({tag, "_wait_noreq"}, {31'd0, inst_req}, 32'd0);
    chk({tag, "_wait_novalid"}, {31'd0, valid_o}, 32'd0);
    e.pc = pc; e.inst = rdata; e.exc = 32'd0;
    sb_q.push_back(e);
    inst_data_ok = 1'b1;
    inst_rdata   = rdata;
    cyc();
    inst_data_ok = 1'b0;
  endtask

  // Compare the presented instruction against the oldest queued expectation.
  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"},   pc_o,             e.pc);
      chk({tag, "_inst"}, inst_o,           e.inst);
      chk({tag, "_exc"},  exception_type_o, e.exc);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] held_pc;
    logic [31:0] held_inst;
    n_total = 0;
    n_pass  = 0;
    rst = 1'b0; stall = 4'd0; exception = 1'b0; exception_pc = 32'd0;
    branch_flag = 1'b0; branch_target = 32'd0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;

    // Reset for two cycles
    cyc();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_req",   {31'd0, inst_req}, 32'd0);
    chk("rst_pc_o",  pc_o, 32'd0);
    chk("rst_inst_o", inst_o, 32'd0);
    chk("rst_exc_o", exception_type_o, 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // 1: basic fetch, then sequential next request
    do_req("t1", 32'hBFC0_0000);
    do_data("t1", 32'hBFC0_0000, 32'h2408_0001);
    check_out("t1");
    cyc();
    do_req("t1_next", 32'hBFC0_0004);

    // 2: stall holds the presentation
    do_data("t2", 32'hBFC0_0004, 32'h3C1D_8000);
    held_pc = pc_o; held_inst = inst_o;
    check_out("t2");
    stall = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_hold_pc",   pc_o,   held_pc);
      chk("t2_hold_inst", inst_o, held_inst);
      chk("t2_hold_noreq", {31'd0, inst_req}, 32'd0);
    end
    stall = 4'b0000;
    cyc();
    do_req("t2_next", 32'hBFC0_0008);

    // 3: taken branch on advance; branch while waiting is ignored
    do_data("t3", 32'hBFC0_0008, 32'h1000_003E);
    check_out("t3");
    branch_flag = 1'b1; branch_target = 32'hBFC0_0100;
    cyc();
    branch_flag = 1'b0;
    do_req("t3_br", 32'hBFC0_0100);
    branch_flag = 1'b1; branch_target = 32'h1234_5678;
    do_data("t3_ign", 32'hBFC0_0100, 32'h0000_0000);
    branch_flag = 1'b0;
    check_out("t3_ign");
    cyc();
    do_req("t3_seq", 32'hBFC0_0104);

    // 4: exception while waiting; in-flight data discarded
    exception = 1'b1; exception_pc = 32'hBFC0_0380;
    cyc();
    exception = 1'b0;
    chk("t4_novalid", {31'd0, valid_o}, 32'd0);
    chk("t4_noreq",   {31'd0, inst_req}, 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    cyc();
    inst_data_ok = 1'b0;
    chk("t4_drop_novalid", {31'd0, valid_o}, 32'd0);
    do_req("t4_redir", 32'hBFC0_0380);
    do_data("t4", 32'hBFC0_0380, 32'h4200_0018);
    check_out("t4");
    cyc();

    // 5: misaligned exception target raises AdEL without a bus request
    exception = 1'b1; exception_pc = 32'h8000_0002;
    cyc();
    exception = 1'b0;
    chk("t5_noreq", {31'd0, inst_req}, 32'd0);
    e.pc = 32'h8000_0002; e.inst = 32'd0; e.exc = 32'h0000_4000;
    sb_q.push_back(e);
    cyc();
    check_out("t5");
    exception = 1'b1; exception_pc = 32'hBFC0_0200;
    cyc();
    exception = 1'b0;
    chk("t5_flush_novalid", {31'd0, valid_o}, 32'd0);
    do_req("t5_redir", 32'hBFC0_0200);

    // 6: reset while waiting
    rst = 1'b0;
    chk("t6_pre_wait", {31'd0, inst_req}, 32'd0);
    cyc();
    chk("t6_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_pc_o",  pc_o, 32'd0);
    chk("t6_inst_o", inst_o, 32'd0);
    chk("t6_req",   {31'd0, inst_req}, 32'd0);
    rst = 1'b1;
    cyc();
    do_req("t6_refetch", 32'hBFC0_0000);
    do_data("t6", 32'hBFC0_0000, 32'h0BAD_F00D);
    check_out("t6");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
